// File: rtl/light_conflict_monitor.sv
// Safety monitor for the highway/farm lamp outputs: latches the first encoding, conflict,
// phase-order or short-yellow violation and requests flash mode. MON_STATS_EN adds fault_cnt.
module light_conflict_monitor #(
    parameter int unsigned TICK_DIV      = 4,
    parameter int unsigned YEL_MIN_TICKS = 2,
    parameter int unsigned INV_PERSIST   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_en
`ifdef MON_STATS_EN
    ,
    output logic [7:0] fault_cnt
`endif
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned YEL_W = $clog2(YEL_MIN_TICKS + 1);
    localparam int unsigned INV_W = $clog2(INV_PERSIST + 1);

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [YEL_W-1:0] YEL_MIN  = YEL_W'(YEL_MIN_TICKS);
    localparam logic [INV_W-1:0] INV_MAX  = INV_W'(INV_PERSIST);

    logic [DIV_W-1:0]      r_div;
    logic [1:0][2:0]       r_prev;
    logic [1:0][YEL_W-1:0] r_yel;
    logic [1:0][INV_W-1:0] r_inv;
    logic [1:0]            r_armed;
    logic                  r_fault;
    logic [2:0]            r_code;

    logic [1:0][2:0]       w_code;
    logic [1:0]            w_valid;
    logic [1:0][2:0]       w_prev_d;
    logic [1:0][YEL_W-1:0] w_yel_d;
    logic [1:0][INV_W-1:0] w_inv_d;
    logic [1:0]            w_armed_d;
    logic                  w_tick;
    logic                  w_inv_cond;
    logic                  w_conf_cond;
    logic                  w_trans_cond;
    logic                  w_short_cond;
    logic [2:0]            w_new_code;
    logic                  w_any;
    logic                  w_clear;
    logic                  w_fault_d;
    logic [2:0]            w_code_d;

    always_comb begin
        w_code[0]    = light_highway;
        w_code[1]    = light_farm;
        w_tick       = (r_div == DIV_LAST);
        w_inv_cond   = 1'b0;
        w_trans_cond = 1'b0;
        w_short_cond = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_valid[i]   = $onehot(w_code[i]);
            w_prev_d[i]  = w_valid[i] ? w_code[i] : r_prev[i];
            w_armed_d[i] = r_armed[i] | w_valid[i];
            w_yel_d[i]   = r_yel[i];
            w_inv_d[i]   = r_inv[i];
            if (!w_valid[i]) begin
                if (r_inv[i] != INV_MAX) w_inv_d[i] = r_inv[i] + INV_W'(1);
                if (w_inv_d[i] == INV_MAX) w_inv_cond = 1'b1;
            end else begin
                w_inv_d[i] = '0;
                // Entry into yellow restarts the count; ticks only count on later cycles.
                if (w_code[i] == YELLOW) begin
                    if (!r_armed[i] || r_prev[i] != YELLOW) begin
                        w_yel_d[i] = '0;
                    end else if (w_tick && r_yel[i] != YEL_MIN) begin
                        w_yel_d[i] = r_yel[i] + YEL_W'(1);
                    end
                end
                if (r_armed[i] && w_code[i] != r_prev[i]) begin
                    if (r_prev[i] == YELLOW && w_code[i] == RED) begin
                        if (r_yel[i] < YEL_MIN) w_short_cond = 1'b1;
                    end else if (!(r_prev[i] == GREEN && w_code[i] == YELLOW) &&
                                 !(r_prev[i] == RED && w_code[i] == GREEN)) begin
                        w_trans_cond = 1'b1;
                    end
                end
            end
        end
        w_conf_cond = w_valid[0] && w_valid[1] && (w_code[0] != RED) && (w_code[1] != RED);

        if (w_inv_cond)        w_new_code = 3'd1;
        else if (w_conf_cond)  w_new_code = 3'd2;
        else if (w_trans_cond) w_new_code = 3'd3;
        else if (w_short_cond) w_new_code = 3'd4;
        else                   w_new_code = 3'd0;
        w_any   = (w_new_code != 3'd0);
        w_clear = fault_clr && !w_any;

        w_fault_d = r_fault;
        w_code_d  = r_code;
        if (w_clear) begin
            w_fault_d = 1'b0;
            w_code_d  = 3'd0;
        end else if (w_any && (!r_fault || fault_clr)) begin
            w_fault_d = 1'b1;
            w_code_d  = w_new_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_prev  <= '0;
            r_yel   <= '0;
            r_inv   <= '0;
            r_armed <= '0;
            r_fault <= 1'b0;
            r_code  <= 3'd0;
        end else begin
            r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
            r_prev  <= w_prev_d;
            r_fault <= w_fault_d;
            r_code  <= w_code_d;
            r_armed <= w_clear ? 2'b00 : w_armed_d;
            if (w_clear && r_fault) begin
                r_yel <= '0;
                r_inv <= '0;
            end else begin
                r_yel <= w_yel_d;
                r_inv <= w_inv_d;
            end
        end
    end

`ifdef MON_STATS_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_fault_d && !r_fault && r_cnt != 8'hff) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign fault_cnt = r_cnt;
`endif

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign flash_en   = r_fault;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Scoreboard bench for light_conflict_monitor: directed scenarios plus random lamp traffic,
// checked against a rule-level model of the monitor.
module tb_light_conflict_monitor;

    localparam int TICK_DIV      = 4;
    localparam int YEL_MIN_TICKS = 2;
    localparam int INV_PERSIST   = 2;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] light_highway = 3'b000;
    logic [2:0] light_farm = 3'b000;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_en;
`ifdef MON_STATS_EN
    logic [7:0] fault_cnt;
`endif

    light_conflict_monitor #(
        .TICK_DIV      (TICK_DIV),
        .YEL_MIN_TICKS (YEL_MIN_TICKS),
        .INV_PERSIST   (INV_PERSIST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .light_highway (light_highway),
        .light_farm    (light_farm),
        .fault_clr     (fault_clr),
        .fault         (fault),
        .fault_code    (fault_code),
        .flash_en      (flash_en)
`ifdef MON_STATS_EN
        ,
        .fault_cnt     (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       f;
        logic [2:0] code;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: each road's last valid lamp, arm flag, whole ticks seen in
    // the current yellow, and length of the current run of invalid samples.
    int m_k;
    int m_prev[2];
    bit m_armed[2];
    int m_yel[2];
    int m_inv[2];
    bit m_fault;
    int m_code;
    int m_cnt;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge(input logic [2:0] hw, input logic [2:0] fm, input bit clr,
                              input bit rst, input string nm);
        int  c[2];
        bit  valid[2];
        bit  cond[5];
        int  n_prev[2];
        bit  n_armed[2];
        int  n_yel[2];
        int  n_inv[2];
        bit  tick;
        int  newc;
        exp_t x;
        if (rst) begin
            m_k = 0;
            m_prev = '{0, 0};
            m_armed = '{0, 0};
            m_yel = '{0, 0};
            m_inv = '{0, 0};
            m_fault = 0;
            m_code = 0;
            m_cnt = 0;
        end else begin
            c[0] = int'(hw);
            c[1] = int'(fm);
            tick = (m_k % TICK_DIV) == (TICK_DIV - 1);
            m_k++;
            cond = '{default: 1'b0};
            for (int i = 0; i < 2; i++) valid[i] = ($countones(c[i][2:0]) == 1);
            if (valid[0] && valid[1] && c[0] != int'(R) && c[1] != int'(R)) cond[2] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                n_prev[i] = m_prev[i];
                n_armed[i] = m_armed[i];
                n_yel[i] = m_yel[i];
                if (!valid[i]) begin
                    n_inv[i] = imin(m_inv[i] + 1, INV_PERSIST);
                    if (n_inv[i] == INV_PERSIST) cond[1] = 1'b1;
                end else begin
                    n_inv[i] = 0;
                    if (m_armed[i] && c[i] != m_prev[i]) begin
                        if (m_prev[i] == int'(Y) && c[i] == int'(R)) begin
                            if (m_yel[i] < YEL_MIN_TICKS) cond[4] = 1'b1;
                        end else if (!((m_prev[i] == int'(G) && c[i] == int'(Y)) ||
                                       (m_prev[i] == int'(R) && c[i] == int'(G)))) begin
                            cond[3] = 1'b1;
                        end
                    end
                    if (c[i] == int'(Y)) begin
                        if (m_armed[i] && m_prev[i] == int'(Y))
                            n_yel[i] = tick ? imin(m_yel[i] + 1, YEL_MIN_TICKS) : m_yel[i];
                        else
                            n_yel[i] = 0;
                    end
                    n_prev[i] = c[i];
                    n_armed[i] = 1'b1;
                end
            end
            newc = 0;
            for (int k = 4; k >= 1; k--) if (cond[k]) newc = k;
            if (clr && newc == 0) begin
                if (m_fault) begin
                    n_yel = '{0, 0};
                    n_inv = '{0, 0};
                end
                n_armed = '{0, 0};
                m_fault = 0;
                m_code = 0;
            end else if (newc != 0 && (!m_fault || clr)) begin
                if (!m_fault) m_cnt = imin(m_cnt + 1, 255);
                m_fault = 1;
                m_code = newc;
            end
            m_prev = n_prev;
            m_armed = n_armed;
            m_yel = n_yel;
            m_inv = n_inv;
        end
        x.name = nm;
        x.f = m_fault;
        x.code = 3'(m_code);
        x.cnt = 8'(m_cnt);
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic [2:0] hw, input logic [2:0] fm, input bit clr,
                         input bit rst, input string nm);
        @(negedge clk);
        light_highway = hw;
        light_farm = fm;
        fault_clr = clr;
        rst_n = !rst;
        model_edge(hw, fm, clr, rst, nm);
    endtask

    task automatic hold(input logic [2:0] hw, input logic [2:0] fm, input int n,
                        input string nm);
        for (int i = 0; i < n; i++) drive(hw, fm, 1'b0, 1'b0, nm);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (fault !== e.f || flash_en !== e.f || fault_code !== e.code
`ifdef MON_STATS_EN
                || fault_cnt !== e.cnt
`endif
               ) begin
                n_bad++;
`ifdef MON_STATS_EN
                $display("FAIL %s @%0t: got fault=%b flash=%b code=%0d cnt=%0d, want fault=%b code=%0d cnt=%0d",
                         e.name, $time, fault, flash_en, fault_code, fault_cnt, e.f, e.code, e.cnt);
`else
                $display("FAIL %s @%0t: got fault=%b flash=%b code=%0d, want fault=%b code=%0d",
                         e.name, $time, fault, flash_en, fault_code, e.f, e.code);
`endif
            end
        end
    end

    initial begin
        logic [2:0] vals[3];
        logic [2:0] hw;
        logic [2:0] fm;
        int         wait_cyc;
        vals[0] = G;
        vals[1] = Y;
        vals[2] = R;

        drive(G, R, 1'b0, 1'b1, "reset");
        drive(G, R, 1'b0, 1'b1, "reset");

        for (int n = 0; n < 5; n++) begin
            hold(G, R, 3, "legal_hw_green");
            hold(Y, R, 12, "legal_hw_yellow");
            hold(R, R, 2, "legal_all_red");
            hold(R, G, 3, "legal_fm_green");
            hold(R, Y, 12, "legal_fm_yellow");
            hold(R, R, 2, "legal_all_red2");
        end

        hold(G, G, 1, "conflict");
        hold(G, R, 3, "conflict_frozen");
        drive(G, R, 1'b1, 1'b0, "clear_clean");
        hold(G, R, 2, "after_clear");
        hold(G, G, 1, "conflict2");
        drive(G, G, 1'b1, 1'b0, "clear_during_conflict");
        drive(G, G, 1'b0, 1'b1, "reset_mid_fault");

        hold(G, R, 2, "inv_setup");
        hold(3'b011, R, 1, "inv_one_cycle");
        hold(G, R, 2, "inv_recovered");
        hold(3'b011, R, 2, "inv_two_cycles");
        drive(G, R, 1'b1, 1'b0, "inv_clear");

        hold(G, R, 1, "order_arm");
        hold(R, R, 1, "green_to_red");
        drive(R, R, 1'b1, 1'b0, "order_clear");
        hold(R, R, 1, "rearm");
        hold(G, R, 1, "rearm_green");
        hold(Y, R, 4, "short_yellow_hold");
        hold(R, R, 1, "short_yellow");
        drive(R, R, 1'b1, 1'b0, "short_clear");

        drive(R, R, 1'b0, 1'b1, "reset2");
        hold(G, 3'b110, 2, "inv_beats_conflict");
        drive(R, R, 1'b0, 1'b1, "reset3");
        hold(G, G, 1, "conflict_first");
        hold(G, 3'b110, 2, "conflict_first_frozen");

        hw = R;
        fm = R;
        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 3) hw = vals[r];
            else if (r == 3) hw = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 15);
            if (r < 3) fm = vals[r];
            else if (r == 3) fm = 3'($urandom_range(0, 7));
            drive(hw, fm, ($urandom_range(0, 9) == 0), ($urandom_range(0, 149) == 0), "random");
        end
        drive(R, R, 1'b0, 1'b1, "final_reset");

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
Independent safety checker on the output side of the highway/farm traffic light controller. Samples both 3-bit lamp codes every clock and checks four things: encoding validity, cross-road conflicts, legal phase order and minimum yellow time. The first violation is latched as a fault code and drives a flash-mode request to the lamp driver. It sits between the controller outputs and the lamp drivers and shares the controller's clock and reset.

Parameters:
TICK_DIV, 4, clock cycles per timing tick; the tick is 1 s in silicon and 4 cycles for the bench.
YEL_MIN_TICKS, 2, minimum number of whole ticks a yellow must be observed before red.
INV_PERSIST, 2, consecutive cycles an invalid encoding must persist before a fault.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
light_highway  input  3  highway lamp code: 001 green, 010 yellow, 100 red
light_farm  input  3  farm lamp code, same encoding
fault_clr  input  1  request to clear the latched fault
fault  output  1  latched fault flag
fault_code  output  3  0 none, 1 invalid code, 2 conflict, 3 illegal transition, 4 short yellow
flash_en  output  1  flash-mode request to the lamp drivers; equal to fault

Behaviour:
- Reset (rst_n low at a clk edge):
  - fault=0, fault_code=0, flash_en=0.
  - Tick divider=0; both yellow counters=0; both invalid-persist counters=0.
  - armed=0.
- Tick divider:
  - Counts 0..TICK_DIV-1 and wraps; tick=1 in the cycle where the count equals TICK_DIV-1.
  - Free-running. Never cleared except by reset.
- Per-road tracker, identical for highway and farm:
  - Registers prev_code, holding the last valid code.
  - Yellow counter: cleared on entry to yellow; increments on each tick while the code is yellow; saturates at YEL_MIN_TICKS.
  - Invalid encoding (not one-hot): persist counter increments each cycle, saturating at INV_PERSIST; any valid code clears it. When it reaches INV_PERSIST, condition 1 is raised. An invalid code never updates prev_code.
- Arming:
  - armed=0 after reset and after a successful clear.
  - The first valid sample loads prev_code and sets armed=1. No transition check is made on that sample.
- Transition check (armed, valid code, code differs from prev_code):
  - Legal: green->yellow, yellow->red, red->green.
  - Any other change raises condition 3.
  - yellow->red with yellow counter < YEL_MIN_TICKS raises condition 4 instead of 3.
- Conflict: in any cycle where both codes are valid and neither is red, condition 2 is raised. No persistence filter.
- Latch:
  - Conditions are evaluated on the inputs sampled at edge N.
  - If fault=0 and any condition is raised, fault=1 and fault_code is set to the lowest-numbered raised condition, visible after edge N (1-cycle latency).
  - While fault=1, fault_code is frozen; later violations are ignored.
- Clear:
  - fault_clr=1 with no condition raised in the same cycle: fault=0, fault_code=0, armed=0, yellow and persist counters cleared.
  - fault_clr=1 with a condition raised: fault stays 1 and fault_code is reloaded with the new condition.
  - fault_clr=1 while fault=0: no effect except armed=0.
- Reset mid-fault clears everything in the same edge; reset has priority over fault_clr.
- Trackers keep running while faulted, so a clear resumes correctly on the next sample.

Optional Feature:
MON_STATS_EN
- Defined: adds output port fault_cnt[7:0].
  - Increments on every 0->1 edge of fault, saturating at 255.
  - Cleared only by reset; unaffected by fault_clr.
- Not defined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Legal sequences, no fault:
  - Highway 001->010 held 3 ticks->100, farm 100->001->010 held 3 ticks->100, repeated 5 cycles -> fault=0, fault_code=0 throughout.
- Conflict:
  - Both roads 001 in the same cycle -> fault=1, fault_code=2 one cycle later, flash_en=1.
- Invalid encoding:
  - Highway 011 for 1 cycle then 001 -> no fault.
  - Highway 011 for 2 cycles -> fault_code=1 after the second sample.
- Phase order and yellow timing:
  - Highway 001->100 directly -> fault_code=3.
  - After clear and re-arm, highway 010 held 1 tick then 100 -> fault_code=4.
- Simultaneous conditions:
  - Farm 110 persisting while both codes otherwise green -> fault_code=1, lowest code wins once persistence is met. Conflict alone fires first if it occurs earlier.
- Clear and reset:
  - fault_clr with clean inputs -> fault=0 next cycle.
  - fault_clr during an active conflict -> fault stays 1, code=2.
  - rst_n=0 mid-fault -> all outputs 0 after that edge.
  - With MON_STATS_EN defined: fault_cnt counts 3 after three fault events, survives fault_clr, and is 0 after reset.
